// File: rtl/expr_eval.sv
// expr_eval: evaluates single-digit ASCII expressions of the form D(opD)*=
// where op is '+' or '*'. Multiplication binds tighter than addition.
// On '=' it emits the result, a malformed flag and a one-cycle done pulse.
// All arithmetic wraps modulo 2^WIDTH.
module expr_eval #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [7:0]       in,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        EXP_DIGIT = 2'd0,
        EXP_OP    = 2'd1,
        BAD       = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0] term, term_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic             done_nxt, err_nxt;

    logic             is_digit, is_plus, is_mul, is_eq;
    logic [WIDTH-1:0] digit_val;

    // For '0'..'9' the low nibble of the ASCII code is exactly the digit value.
    assign is_digit  = (in >= 8'h30) && (in <= 8'h39);
    assign is_plus   = (in == 8'h2B);
    assign is_mul    = (in == 8'h2A);
    assign is_eq     = (in == 8'h3D);
    assign digit_val = WIDTH'(in[3:0]);

    // Next-state, accumulator and output decode; everything holds unless a character is consumed.
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        term_nxt   = term;
        result_nxt = result;
        err_nxt    = err;
        done_nxt   = 1'b0;

        if (in_valid) begin
            case (state)
                EXP_DIGIT: begin
                    if (is_digit) begin
                        term_nxt  = term * digit_val;
                        state_nxt = EXP_OP;
                    end else if (is_eq) begin
                        result_nxt = '0;
                        err_nxt    = 1'b1;
                        done_nxt   = 1'b1;
                        acc_nxt    = '0;
                        term_nxt   = WIDTH'(1);
                        state_nxt  = EXP_DIGIT;
                    end else begin
                        state_nxt = BAD;
                    end
                end
                EXP_OP: begin
                    if (is_mul) begin
                        state_nxt = EXP_DIGIT;
                    end else if (is_plus) begin
                        acc_nxt   = acc + term;
                        term_nxt  = WIDTH'(1);
                        state_nxt = EXP_DIGIT;
                    end else if (is_eq) begin
                        result_nxt = acc + term;
                        err_nxt    = 1'b0;
                        done_nxt   = 1'b1;
                        acc_nxt    = '0;
                        term_nxt   = WIDTH'(1);
                        state_nxt  = EXP_DIGIT;
                    end else begin
                        state_nxt = BAD;
                    end
                end
                BAD: begin
                    if (is_eq) begin
                        result_nxt = '0;
                        err_nxt    = 1'b1;
                        done_nxt   = 1'b1;
                        acc_nxt    = '0;
                        term_nxt   = WIDTH'(1);
                        state_nxt  = EXP_DIGIT;
                    end
                end
                default: begin
                    acc_nxt   = '0;
                    term_nxt  = WIDTH'(1);
                    state_nxt = EXP_DIGIT;
                end
            endcase
        end
    end

    // State, accumulators and registered outputs; clr discards any partial expression.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= EXP_DIGIT;
            acc    <= '0;
            term   <= WIDTH'(1);
            result <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            term   <= term_nxt;
            result <= result_nxt;
            done   <= done_nxt;
            err    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_expr_eval.sv
// tb_expr_eval: drives two expr_eval instances (WIDTH=16 and WIDTH=8) with
// directed and random character streams and compares every cycle against a
// string-parsing reference model.
module tb_expr_eval;

    logic        clk;
    logic        clr;
    logic        in_valid;
    logic [7:0]  in_char;
    logic [15:0] result16;
    logic        done16, err16;
    logic [7:0]  result8;
    logic        done8, err8;

    int checks = 0;
    int errors = 0;

    // Reference model: characters of the pending expression plus expected outputs.
    byte              pend[$];
    logic [63:0]      exp_res;
    logic             exp_err;
    logic             exp_done;

    expr_eval #(.WIDTH(16)) dut16 (
        .clk      (clk),
        .clr      (clr),
        .in_valid (in_valid),
        .in       (in_char),
        .result   (result16),
        .done     (done16),
        .err      (err16)
    );

    expr_eval #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .clr      (clr),
        .in_valid (in_valid),
        .in       (in_char),
        .result   (result8),
        .done     (done8),
        .err      (err8)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Parse a pending expression: digits at even positions, '+'/'*' at odd
    // positions, odd length. Value is a sum of products in 64-bit wrapping
    // arithmetic, which is exact modulo 2^16 and 2^8.
    task automatic evaluate(input byte q[$], output bit ok, output logic [63:0] val);
        longint unsigned sum, prod;
        ok = (q.size() % 2) == 1;
        for (int i = 0; i < q.size(); i++) begin
            if (i % 2 == 0) begin
                if (q[i] < "0" || q[i] > "9") ok = 0;
            end else begin
                if (q[i] != "+" && q[i] != "*") ok = 0;
            end
        end
        sum  = 0;
        prod = 1;
        if (ok) begin
            for (int i = 0; i < q.size(); i++) begin
                if (i % 2 == 0) prod = prod * longint'(q[i] - "0");
                else if (q[i] == "+") begin
                    sum  = sum + prod;
                    prod = 1;
                end
            end
            sum = sum + prod;
        end
        val = ok ? sum : 64'd0;
    endtask

    task automatic check_all();
        check("done16",   {63'd0, done16}, {63'd0, exp_done});
        check("err16",    {63'd0, err16},  {63'd0, exp_err});
        check("result16", {48'd0, result16}, {48'd0, exp_res[15:0]});
        check("done8",    {63'd0, done8},  {63'd0, exp_done});
        check("err8",     {63'd0, err8},   {63'd0, exp_err});
        check("result8",  {56'd0, result8}, {56'd0, exp_res[7:0]});
    endtask

    // One clock cycle: present a character, let the edge consume it, update the model, compare.
    task automatic applyStimulus(input bit v, input byte c);
        bit          ok;
        logic [63:0] val;
        in_valid = v;
        in_char  = c;
        @(posedge clk);
        #1;
        exp_done = 1'b0;
        if (v) begin
            if (c == "=") begin
                evaluate(pend, ok, val);
                exp_done = 1'b1;
                exp_err  = !ok;
                exp_res  = val;
                pend.delete();
            end else begin
                pend.push_back(c);
            end
        end
        in_valid = 1'b0;
        check_all();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) applyStimulus(1'b1, s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, byte'($urandom_range(32, 126)));
    endtask

    // Asynchronous reset pulse placed between clock edges, outputs checked while clr is high.
    task automatic pulse_clr();
        #2 clr = 1'b1;
        #2;
        check("clr_result16", {48'd0, result16}, 64'd0);
        check("clr_done16",   {63'd0, done16},   64'd0);
        check("clr_err16",    {63'd0, err16},    64'd0);
        check("clr_result8",  {56'd0, result8},  64'd0);
        clr = 1'b0;
        pend.delete();
        exp_res  = '0;
        exp_err  = 1'b0;
        exp_done = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] r16, input logic [7:0] r8, input bit e);
        check({tag, "_r16"}, {48'd0, result16}, {48'd0, r16});
        check({tag, "_r8"},  {56'd0, result8},  {56'd0, r8});
        check({tag, "_err"}, {63'd0, err16},    {63'd0, e});
    endtask

    initial begin
        clr      = 1'b1;
        in_valid = 1'b0;
        in_char  = 8'h00;
        exp_res  = '0;
        exp_err  = 1'b0;
        exp_done = 1'b0;
        #7;
        check_all();
        #5 clr = 1'b0;

        // Precedence: 1 + 2*3.
        send_str("1+2*3=");
        checkOutput("prec", 16'd7, 8'd7, 1'b0);
        idle(1);
        check("done_one_cycle", {63'd0, done16}, 64'd0);

        // Wraparound: 9^5 = 59049, and 169 modulo 256.
        send_str("9*9*9*9*9=");
        checkOutput("wrap", 16'd59049, 8'd169, 1'b0);

        // Malformed inputs and recovery.
        send_str("1+*2=");
        checkOutput("bad_op", 16'd0, 8'd0, 1'b1);
        send_str("4=");
        checkOutput("recover", 16'd4, 8'd4, 1'b0);
        send_str("3a=");
        checkOutput("bad_char", 16'd0, 8'd0, 1'b1);
        send_str("=");
        checkOutput("empty", 16'd0, 8'd0, 1'b1);
        send_str("12=");
        checkOutput("multidigit", 16'd0, 8'd0, 1'b1);
        send_str("7+=");
        checkOutput("trailing_op", 16'd0, 8'd0, 1'b1);

        // Gap in in_valid mid-expression.
        send_str("2");
        idle(3);
        send_str("+3*0+1=");
        checkOutput("gap", 16'd3, 8'd3, 1'b0);

        // Reset in the middle of an expression.
        send_str("5*");
        pulse_clr();
        send_str("2=");
        checkOutput("midclr", 16'd2, 8'd2, 1'b0);

        // Back-to-back expressions with a double terminator.
        send_str("8=");
        checkOutput("b2b_first", 16'd8, 8'd8, 1'b0);
        send_str("9+1=");
        checkOutput("b2b_second", 16'd10, 8'd10, 1'b0);
        send_str("=");
        checkOutput("b2b_empty", 16'd0, 8'd0, 1'b1);

        // Random expressions, mostly well formed, with gaps, corruption and resets.
        for (int e = 0; e < 120; e++) begin
            int nterms;
            nterms = $urandom_range(1, 7);
            for (int t = 0; t < nterms; t++) begin
                if ($urandom_range(0, 19) == 0)
                    applyStimulus(1'b1, byte'($urandom_range(32, 126)));
                else
                    applyStimulus(1'b1, byte'(8'h30 + $urandom_range(0, 9)));
                if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
                if (t != nterms - 1)
                    applyStimulus(1'b1, ($urandom_range(0, 1) == 0) ? byte'("+") : byte'("*"));
            end
            if ($urandom_range(0, 14) == 0) pulse_clr();
            applyStimulus(1'b1, "=");
        end

        // Unstructured random characters with random qualification.
        for (int i = 0; i < 300; i++) begin
            string pool;
            pool = "0123456789+*=+*=a";
            applyStimulus($urandom_range(0, 3) != 0, pool[$urandom_range(0, pool.len() - 1)]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
